// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates trap/mret/branch redirects and sequences
// stalls/flushes for load-use hazards and multi-cycle LSU accesses.
module pipe_ctrl #(
    parameter int XLEN      = 64,
    parameter int STALL_MAX = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_en_i,
    input  logic [XLEN-1:0] br_addr_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            mret_req_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            load_use_i,
    input  logic            mem_busy_i,
    output logic            pc_jump_en_o,
    output logic [XLEN-1:0] pc_jump_addr_o,
    output logic            pc_stall_en_o,
    output logic            if_id_stall_o,
    output logic            id_ex_stall_o,
    output logic            ex_mem_stall_o,
    output logic            if_id_flush_o,
    output logic            id_ex_flush_o,
    output logic            trap_commit_o,
    output logic            hang_o
);
    localparam int CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {RUN, WAIT, REDIR} state_t;

    state_t          state;
    logic            pend_valid;
    logic            pend_trap;
    logic            pend_mret;
    logic [XLEN-1:0] pend_addr;
    logic [CW-1:0]   wait_cnt;
    logic            hang;

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic [1:0]      req_prio;
    logic [1:0]      pend_prio;
    logic [CW-1:0]   cnt_inc;

    // Priority ranks: trap=3, mret=2, branch=1, none=0.
    always_comb begin
        req_valid = trap_req_i | mret_req_i | br_en_i;
        req_addr  = '0;
        req_prio  = 2'd0;
        if (trap_req_i) begin
            req_addr = trap_vec_i;
            req_prio = 2'd3;
        end else if (mret_req_i) begin
            req_addr = mepc_i;
            req_prio = 2'd2;
        end else if (br_en_i) begin
            req_addr = br_addr_i;
            req_prio = 2'd1;
        end
        pend_prio = pend_trap ? 2'd3 : pend_mret ? 2'd2 : pend_valid ? 2'd1 : 2'd0;
        cnt_inc   = (wait_cnt == CW'(STALL_MAX)) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
            pend_mret  <= 1'b0;
            pend_addr  <= '0;
            wait_cnt   <= '0;
            hang       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy_i) begin
                        pend_valid <= req_valid;
                        pend_trap  <= trap_req_i;
                        pend_mret  <= ~trap_req_i & mret_req_i;
                        pend_addr  <= req_addr;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (req_prio > pend_prio) begin
                        pend_valid <= 1'b1;
                        pend_trap  <= trap_req_i;
                        pend_mret  <= ~trap_req_i & mret_req_i;
                        pend_addr  <= req_addr;
                    end
                    wait_cnt <= cnt_inc;
                    if (cnt_inc == CW'(STALL_MAX))
                        hang <= 1'b1;
                    // A redirect landing in the exit cycle is latched above, so replay it too.
                    if (!mem_busy_i) begin
                        if (pend_valid || req_valid) begin
                            state <= REDIR;
                        end else begin
                            state    <= RUN;
                            wait_cnt <= '0;
                        end
                    end
                end
                REDIR: begin
                    pend_valid <= 1'b0;
                    pend_trap  <= 1'b0;
                    pend_mret  <= 1'b0;
                    pend_addr  <= '0;
                    wait_cnt   <= '0;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_jump_en_o   = 1'b0;
        pc_jump_addr_o = '0;
        pc_stall_en_o  = 1'b0;
        if_id_stall_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        trap_commit_o  = 1'b0;
        hang_o         = rst & hang;
        if (rst) begin
            case (state)
                RUN: begin
                    if (mem_busy_i) begin
                        pc_stall_en_o  = 1'b1;
                        if_id_stall_o  = 1'b1;
                        id_ex_stall_o  = 1'b1;
                        ex_mem_stall_o = 1'b1;
                    end else if (req_valid) begin
                        pc_jump_en_o   = 1'b1;
                        pc_jump_addr_o = req_addr;
                        if_id_flush_o  = 1'b1;
                        id_ex_flush_o  = 1'b1;
                        trap_commit_o  = trap_req_i;
                    end else if (load_use_i) begin
                        pc_stall_en_o  = 1'b1;
                        if_id_stall_o  = 1'b1;
                        id_ex_flush_o  = 1'b1;
                    end
                end
                WAIT: begin
                    pc_stall_en_o  = 1'b1;
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                end
                REDIR: begin
                    pc_jump_en_o   = 1'b1;
                    pc_jump_addr_o = pend_addr;
                    if_id_flush_o  = 1'b1;
                    id_ex_flush_o  = 1'b1;
                    trap_commit_o  = pend_trap;
                end
                default: ;
            endcase
        end
    end
endmodule
